// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT stage sequencer: state encoding,
// log2 helper and the bit-reversal used for natural-order input addressing.
package fft_pkg;

  localparam int unsigned ADDR_W_MAX = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_NEXT,
    S_DONE
  } state_e;

  function automatic int unsigned log2n(input int unsigned n);
    return $clog2(n);
  endfunction

  // Reverses the low w bits of a; bits at and above w come back zero.
  function automatic logic [ADDR_W_MAX-1:0] bit_rev(input logic [ADDR_W_MAX-1:0] a,
                                                    input int w);
    logic [ADDR_W_MAX-1:0] r;
    r = '0;
    for (int i = 0; i < ADDR_W_MAX; i++) begin
      if (i < w) r[w-1-i] = a[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_stage_sequencer_delay.sv
// Fixed-depth shift register with synchronous active-low clear; carries the
// read strobe and addresses forward so they re-emerge as the write strobe.
module fft_delay_line #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [DEPTH-1:0][WIDTH-1:0] pipe_q, pipe_d;

  always_comb begin
    pipe_d[0] = din;
    for (int i = 1; i < DEPTH; i++) pipe_d[i] = pipe_q[i-1];
  end

  always_ff @(posedge clk) begin
    if (!reset) pipe_q <= '0;
    else        pipe_q <= pipe_d;
  end

  assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/fft_stage_sequencer.sv
// Radix-2 DIT pass sequencer driving a ping-pong RAM: reads, delayed in-place
// writes and bank toggling per stage. FFT_SEQ_BITREV_EN bit-reverses stage-0 reads.
module fft_stage_sequencer
  import fft_pkg::*;
#(
  parameter int unsigned N        = 32,
  parameter int unsigned BFLY_LAT = 3,
  localparam int unsigned LOG2N   = log2n(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [LOG2N-1:0] stage,
  output logic             bank_select,
  output logic             read_en,
  output logic [LOG2N-1:0] rd_address1,
  output logic [LOG2N-1:0] rd_address2,
  output logic [LOG2N-2:0] twiddle_addr,
  output logic             wr_en,
  output logic [LOG2N-1:0] wr_address1,
  output logic [LOG2N-1:0] wr_address2,
  output logic             final_bank
);

  localparam int unsigned D    = BFLY_LAT + 1;
  localparam int unsigned KW   = LOG2N - 1;
  localparam int unsigned CW   = $clog2(D + 1);
  localparam int unsigned DL_W = 1 + 2 * LOG2N;
  localparam logic [KW-1:0]    K_LAST     = KW'(N / 2 - 1);
  localparam logic [LOG2N-1:0] LAST_STAGE = LOG2N'(LOG2N - 1);
  localparam logic [CW-1:0]    CNT_LAST   = CW'(D - 1);
  localparam logic [LOG2N-1:0] ONE        = LOG2N'(1);

  state_e           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [LOG2N-1:0] stage_q, stage_d;
  logic             bank_q, bank_d;
  logic             fin_q, fin_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             rd_en_q, rd_en_d;
  logic [LOG2N-1:0] rd1_q, rd1_d, rd2_q, rd2_d;
  logic [LOG2N-1:0] nat1_q, nat1_d, nat2_q, nat2_d;
  logic [KW-1:0]    tw_q, tw_d;
  logic [LOG2N-1:0] kx, span, a1, a2;
  logic [DL_W-1:0]  wr_bus;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    bank_d  = bank_q;
    fin_d   = fin_q;
    rd_en_d = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_READ;
        k_d     = '0;
        stage_d = '0;
        rd_en_d = 1'b1;
      end
      S_READ: begin
        if (k_q == K_LAST) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          k_d     = k_q + KW'(1);
          rd_en_d = 1'b1;
        end
      end
      S_DRAIN: begin
        if (cnt_q == CNT_LAST) begin
          if (stage_q == LAST_STAGE) begin
            state_d = S_DONE;
            fin_d   = bank_q;
          end else begin
            state_d = S_NEXT;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      // Bank flips only as NEXT hands over to the new stage's first read.
      S_NEXT: begin
        state_d = S_READ;
        stage_d = stage_q + ONE;
        bank_d  = ~bank_q;
        k_d     = '0;
        rd_en_d = 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    kx   = {1'b0, k_d};
    span = ONE << stage_d;
    a1   = ((kx >> stage_d) << (stage_d + ONE)) | (kx & (span - ONE));
    a2   = a1 | span;

    nat1_d = '0;
    nat2_d = '0;
    rd1_d  = '0;
    rd2_d  = '0;
    tw_d   = '0;
    if (rd_en_d) begin
      nat1_d = a1;
      nat2_d = a2;
      rd1_d  = a1;
      rd2_d  = a2;
      tw_d   = (k_d & KW'(span - ONE)) << (LAST_STAGE - stage_d);
`ifdef FFT_SEQ_BITREV_EN
      // Input bank is in natural order; only the first pass reads permuted.
      if (stage_d == '0) begin
        rd1_d = LOG2N'(bit_rev(ADDR_W_MAX'(a1), LOG2N));
        rd2_d = LOG2N'(bit_rev(ADDR_W_MAX'(a2), LOG2N));
      end
`endif
    end

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      cnt_q   <= '0;
      stage_q <= '0;
      bank_q  <= 1'b0;
      fin_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      nat1_q  <= '0;
      nat2_q  <= '0;
      tw_q    <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      bank_q  <= bank_d;
      fin_q   <= fin_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rd_en_q <= rd_en_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      nat1_q  <= nat1_d;
      nat2_q  <= nat2_d;
      tw_q    <= tw_d;
    end
  end

  fft_delay_line #(
    .WIDTH(DL_W),
    .DEPTH(D)
  ) u_wr_dly (
    .clk  (clk),
    .reset(reset),
    .din  ({rd_en_q, nat1_q, nat2_q}),
    .dout (wr_bus)
  );

  assign busy         = busy_q;
  assign done         = done_q;
  assign stage        = stage_q;
  assign bank_select  = bank_q;
  assign read_en      = rd_en_q;
  assign rd_address1  = rd1_q;
  assign rd_address2  = rd2_q;
  assign twiddle_addr = tw_q;
  assign final_bank   = fin_q;
  assign {wr_en, wr_address1, wr_address2} = wr_bus;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Scoreboard bench: a butterfly-enumeration model queues expected reads,
// writes, done pulses and busy cycles; a negedge monitor pops and compares.
module tb_fft_stage_sequencer;

  localparam int N  = 32;
  localparam int BL = 3;
  localparam int L  = $clog2(N);
  localparam int D  = BL + 1;
  localparam int P  = N / 2 + D + 1;

  logic clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic busy, done, bank_select, read_en, wr_en, final_bank;
  logic [L-1:0] stage, rd_address1, rd_address2, wr_address1, wr_address2;
  logic [L-2:0] twiddle_addr;

  fft_stage_sequencer #(.N(N), .BFLY_LAT(BL)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .stage(stage), .bank_select(bank_select), .read_en(read_en),
    .rd_address1(rd_address1), .rd_address2(rd_address2),
    .twiddle_addr(twiddle_addr), .wr_en(wr_en), .wr_address1(wr_address1),
    .wr_address2(wr_address2), .final_bank(final_bank)
  );

  always #5 clk = ~clk;

  // cyc = number of rising edges so far; events are tagged with the edge
  // after which they should be visible.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc; int a1; int a2; int tw; int st; int bank;
  } ev_t;

  ev_t rdq[$], wrq[$], dnq[$];
  bit  busy_map[int];
  int  bank_cur = 0;
  int  checks = 0, failures = 0;
  ev_t me;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cyc=%0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  function automatic int rev(input int v, input int w);
    int r = 0;
    for (int i = 0; i < w; i++) r = (r << 1) | ((v >> i) & 1);
    return r;
  endfunction

  // Expected activity of one transform whose start is sampled at edge t.
  task automatic launch(input int t);
    ev_t e, r;
    int k, span;
    for (int s = 0; s < L; s++) begin
      span = 1 << s;
      k = 0;
      for (int base = 0; base < N; base += 2 * span) begin
        for (int j = 0; j < span; j++) begin
          e.cyc  = t + P * s + k;
          e.a1   = base + j;
          e.a2   = base + j + span;
          e.tw   = j * (N / (2 * span));
          e.st   = s;
          e.bank = bank_cur ^ (s & 1);
          r = e;
`ifdef FFT_SEQ_BITREV_EN
          if (s == 0) begin
            r.a1 = rev(e.a1, L);
            r.a2 = rev(e.a2, L);
          end
`endif
          rdq.push_back(r);
          e.cyc = e.cyc + D;
          wrq.push_back(e);
          k++;
        end
      end
    end
    bank_cur = bank_cur ^ ((L - 1) & 1);
    e.cyc  = t + P * L - 1;
    e.bank = bank_cur;
    dnq.push_back(e);
    for (int c = t; c <= t + P * L - 1; c++) busy_map[c] = 1'b1;
  endtask

  // Reset sampled at edge now+1 abandons everything scheduled from then on.
  task automatic trim(input int now);
    while (rdq.size() > 0 && rdq[rdq.size()-1].cyc > now) void'(rdq.pop_back());
    while (wrq.size() > 0 && wrq[wrq.size()-1].cyc > now) void'(wrq.pop_back());
    while (dnq.size() > 0 && dnq[dnq.size()-1].cyc > now) void'(dnq.pop_back());
    for (int c = now + 1; c < now + 2 * P * L; c++)
      if (busy_map.exists(c)) busy_map.delete(c);
    bank_cur = 0;
  endtask

  task automatic wait_cyc(input int x);
    while (cyc < x) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    while (rdq.size() > 0 && rdq[0].cyc < cyc) begin
      chk("rd_missing", cyc, rdq[0].cyc);
      void'(rdq.pop_front());
    end
    while (wrq.size() > 0 && wrq[0].cyc < cyc) begin
      chk("wr_missing", cyc, wrq[0].cyc);
      void'(wrq.pop_front());
    end
    while (dnq.size() > 0 && dnq[0].cyc < cyc) begin
      chk("done_missing", cyc, dnq[0].cyc);
      void'(dnq.pop_front());
    end
    if (read_en) begin
      if (rdq.size() == 0) chk("rd_unexpected", int'(read_en), 0);
      else begin
        me = rdq.pop_front();
        chk("rd_cyc", cyc, me.cyc);
        chk("rd_a1", int'(rd_address1), me.a1);
        chk("rd_a2", int'(rd_address2), me.a2);
        chk("rd_tw", int'(twiddle_addr), me.tw);
        chk("rd_stage", int'(stage), me.st);
        chk("rd_bank", int'(bank_select), me.bank);
      end
    end
    if (wr_en) begin
      if (wrq.size() == 0) chk("wr_unexpected", int'(wr_en), 0);
      else begin
        me = wrq.pop_front();
        chk("wr_cyc", cyc, me.cyc);
        chk("wr_a1", int'(wr_address1), me.a1);
        chk("wr_a2", int'(wr_address2), me.a2);
        chk("wr_stage", int'(stage), me.st);
        chk("wr_bank", int'(bank_select), me.bank);
      end
    end
    if (done) begin
      if (dnq.size() == 0) chk("done_unexpected", int'(done), 0);
      else begin
        me = dnq.pop_front();
        chk("done_cyc", cyc, me.cyc);
        chk("final_bank", int'(final_bank), me.bank);
      end
    end
    chk("busy", int'(busy), int'(busy_map.exists(cyc)));
  end

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_rd_en"}, int'(read_en), 0);
    chk({tag, "_wr_en"}, int'(wr_en), 0);
    chk({tag, "_bank"}, int'(bank_select), 0);
    chk({tag, "_stage"}, int'(stage), 0);
    chk({tag, "_rd_a1"}, int'(rd_address1), 0);
    chk({tag, "_wr_a2"}, int'(wr_address2), 0);
    chk({tag, "_final_bank"}, int'(final_bank), 0);
  endtask

  initial begin
    int t, n, off;
    wait_cyc(3);
    @(negedge clk);
    chk_idle("reset");
    @(posedge clk); #1;
    reset = 1'b1;

    // Single-pulse starts with spurious start activity while busy.
    for (int it = 0; it < 3; it++) begin
      wait_cyc(cyc + int'($urandom_range(1, 6)));
      start = 1'b1;
      t = cyc + 1;
      launch(t);
      @(posedge clk); #1;
      start = 1'b0;
      n   = $urandom_range(1, 3);
      off = (it == 0) ? 40 : int'($urandom_range(5, P * L - 10));
      wait_cyc(t + off - 1);
      start = 1'b1;
      wait_cyc(t + off - 1 + n);
      start = 1'b0;
      wait_cyc(t + P * L + 1);
    end

    // Start held high: second transform begins right after the IDLE cycle.
    wait_cyc(cyc + int'($urandom_range(1, 4)));
    start = 1'b1;
    t = cyc + 1;
    launch(t);
    launch(t + P * L + 1);
    wait_cyc(t + P * L + 1);
    start = 1'b0;
    wait_cyc(t + 2 * P * L + 3);

    // Reset in the middle of stage 1, then a fresh full transform.
    start = 1'b1;
    t = cyc + 1;
    launch(t);
    @(posedge clk); #1;
    start = 1'b0;
    wait_cyc(t + 29);
    reset = 1'b0;
    trim(cyc);
    @(posedge clk);
    @(negedge clk);
    chk_idle("midreset");
    @(posedge clk); #1;
    reset = 1'b1;
    wait_cyc(cyc + 2 * P);
    start = 1'b1;
    t = cyc + 1;
    launch(t);
    @(posedge clk); #1;
    start = 1'b0;
    wait_cyc(t + P * L + 4);

    chk("rdq_left", rdq.size(), 0);
    chk("wrq_left", wrq.size(), 0);
    chk("dnq_left", dnq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fft_stage_sequencer.md
# fft_stage_sequencer

Control stage that sits directly upstream of the two-bank ping-pong RAM interface and drives it through every radix-2 DIT pass of an N-point FFT. Per stage it issues N/2 butterfly read address pairs plus twiddle index, then emits the matching write pairs after the fixed read-plus-butterfly latency, and toggles `bank_select` between stages. Start/busy/done handshake to the top-level controller.

## Interface
- `N`, 32, FFT length, power of two, ≥ 4
- `BFLY_LAT`, 3, butterfly datapath latency in cycles from RAM read data to computed result
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-low reset
- `start`  in  1  begin a transform; sampled only in IDLE
- `busy`  out  1  high from first read cycle through done cycle
- `done`  out  1  one-cycle pulse on the final cycle of the last stage
- `stage`  out  log2N  current stage index, 0..log2N-1
- `bank_select`  out  1  to RAM interface; 0 = write bank0/read bank1
- `read_en`  out  1  read strobe
- `rd_address1`, `rd_address2`  out  log2N each  butterfly read pair
- `twiddle_addr`  out  log2N-1  twiddle ROM index, aligned with `read_en`
- `wr_en`  out  1  write strobe
- `wr_address1`, `wr_address2`  out  log2N each  butterfly write pair
- `final_bank`  out  1  bank holding the result; valid when `done`

## Operation
- D = 1 + BFLY_LAT (1-cycle RAM read + butterfly).
- States: IDLE, READ, DRAIN, NEXT, DONE.
- IDLE: all strobes low; `start`=1 → READ, k=0, stage=0. `start` outside IDLE ignored.
- READ: one butterfly per cycle, k = 0..N/2-1; span = 1<<stage; addr1 = ((k>>stage)<<(stage+1)) | (k & (span-1)); addr2 = addr1 | span; twiddle = (k & (span-1)) << (log2N-1-stage). After k = N/2-1 → DRAIN.
- DRAIN: exactly D cycles, no reads; write pipeline empties. Then NEXT, or DONE if stage = log2N-1.
- NEXT: one cycle, strobes low, `bank_select` toggles, stage++, k=0 → READ.
- DONE: `done`=1 one cycle, `final_bank` = current `bank_select`, → IDLE.
- Write path: `wr_en`/`wr_address1/2` = `read_en`/`rd_address1/2` delayed exactly D cycles via delay line; write addresses equal read addresses (in-place).
- `bank_select` constant across READ, DRAIN and NEXT's entry; changes only on leaving NEXT, so every write of a stage lands in that stage's write bank.
- Reset values: state IDLE, stage 0, `bank_select` 0, `busy`/`done`/`read_en`/`wr_en` 0, addresses 0, `final_bank` 0, delay line cleared.
- Reset mid-transform: abandon immediately, no further writes, next cycle IDLE values.

## Timing
- All outputs registered.
- `start` sampled at edge t → first `read_en` in cycle t+1.
- Stage s reads: cycles t+1+P·s .. t+N/2+P·s, period P = N/2 + D + 1.
- First write of a stage D cycles after its first read; last write in the final DRAIN cycle.
- `done` at cycle t + P·log2N; N=32, BFLY_LAT=3: P=21, `done` at t+105; `busy` low from t+106.
- `start` held high through DONE: new transform begins on the IDLE cycle after DONE.

## Configuration
- `FFT_SEQ_BITREV_EN` defined: stage-0 read addresses are bit-reversed (input bank holds natural-order samples); stage-0 write addresses stay natural. Stages ≥1 unaffected.
- Undefined: stage-0 reads use natural addresses; input must be pre-permuted in bit-reversed order.

## Structure
- Shared package/header `fft_pkg`: log2N helper constant, state encodings, bit-reverse function.
- Sub-module `fft_delay_line` (width, depth D): synchronous-clear shift register carrying {valid, addr1, addr2}.

## Test plan
- N=8, BFLY_LAT=1, start pulse → stage 0 reads (0,1),(2,3),(4,5),(6,7) tw 0; stage 1 (0,2),(1,3),(4,6),(5,7) tw 0,2,0,2; stage 2 (0,4),(1,5),(2,6),(3,7) tw 0,1,2,3; each write pair repeats 2 cycles later.
- N=32, BFLY_LAT=3 → `done` exactly 105 cycles after start edge, `bank_select` toggles 4 times, `final_bank`=0.
- `start` asserted while busy at cycle t+40 → no effect, `done` still at t+105.
- Reset low at t+30 (mid-stage 1) → next cycle all strobes 0, `bank_select` 0, no `wr_en` afterwards; fresh start runs a full 105-cycle transform.
- `FFT_SEQ_BITREV_EN`, N=8 → stage 0 reads (0,4),(2,6),(1,5),(3,7), writes (0,1),(2,3),(4,5),(6,7).
- Check: no `read_en` in DRAIN/NEXT; `wr_en` never asserted in a cycle where `bank_select` differs from its value at the matching read.
